// File: rtl/lif_cfg_pkg.sv
// Shared types and constants for the LIF neuron configuration loader.
// Define LIF_CFG_CHECKSUM_EN to append an XOR checksum byte to every frame.
package lif_cfg_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, COMMIT} state_e;

`ifdef LIF_CFG_CHECKSUM_EN
  localparam int FRAME_BYTES = 5;
`else
  localparam int FRAME_BYTES = 4;
`endif

  localparam int WEIGHT_W = 16;
  localparam int THRESH_W = 5;
  localparam int DECAY_W  = 3;
  localparam int REFR_W   = 5;

  localparam int IDX_W = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  localparam int B_WLO  = 0;
  localparam int B_WHI  = 1;
  localparam int B_TD   = 2;
  localparam int B_REFR = 3;
  localparam int B_CSUM = 4;

  typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

  typedef struct packed {
    logic [WEIGHT_W-1:0] weights;
    logic [THRESH_W-1:0] threshold;
    logic [DECAY_W-1:0]  decay;
    logic [REFR_W-1:0]   refractory;
  } params_t;

  function automatic params_t unpack_frame(frame_t f);
    params_t p;
    p.weights    = {f[B_WHI], f[B_WLO]};
    p.threshold  = f[B_TD][THRESH_W-1:0];
    p.decay      = f[B_TD][7:THRESH_W];
    p.refractory = f[B_REFR][REFR_W-1:0];
    return p;
  endfunction

endpackage

// File: rtl/lif_config_loader_if.sv
// Byte-wide valid/ready configuration stream into the LIF config loader.
interface lif_config_loader_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_sof;
  logic [7:0] cfg_data;

  modport master (output cfg_valid, output cfg_sof, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_sof, input cfg_data, output cfg_ready);
endinterface

// File: rtl/lif_cfg_frame_check.sv
// Combinational frame validation: reserved refractory bits must be zero and,
// with LIF_CFG_CHECKSUM_EN, the trailing byte must equal the XOR of the others.
module lif_cfg_frame_check
  import lif_cfg_pkg::*;
(
  input  logic [2:0] reserved_bits,
`ifdef LIF_CFG_CHECKSUM_EN
  input  frame_t     frame,
`endif
  output logic       frame_ok
);

`ifdef LIF_CFG_CHECKSUM_EN
  logic [7:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < B_CSUM; i++) sum ^= frame[i];
  end

  assign frame_ok = (reserved_bits == 3'b000) && (sum == frame[B_CSUM]);
`else
  assign frame_ok = (reserved_bits == 3'b000);
`endif

endmodule

// File: rtl/lif_config_loader.sv
// Assembles configuration frames from a byte stream and commits them atomically
// to the LIF neuron parameters. LIF_CFG_CHECKSUM_EN selects the 5-byte frame.
module lif_config_loader
  import lif_cfg_pkg::*;
#(
  parameter logic [WEIGHT_W-1:0] RST_WEIGHTS    = 16'h0000,
  parameter logic [THRESH_W-1:0] RST_THRESHOLD  = 5'd15,
  parameter logic [DECAY_W-1:0]  RST_DECAY      = 3'd1,
  parameter logic [REFR_W-1:0]   RST_REFRACTORY = 5'd4
)
(
  input  logic                clk,
  input  logic                reset,
  lif_config_loader_if.slave  cfg,
  input  logic                run,
  output logic [WEIGHT_W-1:0] weights,
  output logic [THRESH_W-1:0] threshold,
  output logic [DECAY_W-1:0]  decay,
  output logic [REFR_W-1:0]   refractory_period,
  output logic                cfg_loaded,
  output logic                neuron_enable,
  output logic                frame_error
);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             commit;
  logic             err_set;
  logic             ready_st;
  logic             accept;
  logic             frame_ok;
  frame_t           stage;
  params_t          active;

  // Ready is forced low while reset is held so no byte slips in on that edge.
  assign cfg.cfg_ready = ready_st & ~reset;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  lif_cfg_frame_check u_check (
    .reserved_bits (stage[B_REFR][7:REFR_W]),
`ifdef LIF_CFG_CHECKSUM_EN
    .frame         (stage),
`endif
    .frame_ok      (frame_ok)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    wr_idx    = idx;
    commit    = 1'b0;
    err_set   = 1'b0;
    ready_st  = 1'b0;

    unique case (state)
      IDLE: begin
        ready_st = 1'b1;
        if (accept) begin
          if (cfg.cfg_sof) begin
            wr_en     = 1'b1;
            wr_idx    = '0;
            idx_nxt   = IDX_W'(1);
            state_nxt = COLLECT;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      COLLECT: begin
        ready_st = 1'b1;
        if (accept) begin
          wr_en = 1'b1;
          if (cfg.cfg_sof) begin
            // A fresh start-of-frame abandons the partial frame and restarts.
            err_set = 1'b1;
            wr_idx  = '0;
            idx_nxt = IDX_W'(1);
          end else if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = CHECK;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      CHECK: begin
        if (frame_ok) begin
          state_nxt = COMMIT;
        end else begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      // NOTE: the staging bytes are plain flops, not a RAM, so clearing them
      // on reset is cheap and keeps a stale half-frame from ever surviving.
      stage         <= '0;
      active        <= '{weights:    RST_WEIGHTS,
                         threshold:  RST_THRESHOLD,
                         decay:      RST_DECAY,
                         refractory: RST_REFRACTORY};
      cfg_loaded    <= 1'b0;
      neuron_enable <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      if (wr_en) stage[wr_idx] <= cfg.cfg_data;
      if (commit) begin
        active     <= unpack_frame(stage);
        cfg_loaded <= 1'b1;
      end
      neuron_enable <= run & cfg_loaded;
      frame_error   <= err_set;
    end
  end

  assign weights           = active.weights;
  assign threshold         = active.threshold;
  assign decay             = active.decay;
  assign refractory_period = active.refractory;

endmodule

// File: doc/lif_config_loader.md
Name: lif_config_loader

Overview:
- Upstream stage of the LIF neuron; sits between the chip's byte-wide input port and the neuron's parameter inputs.
- Assembles a byte stream, using a valid/ready handshake, into a staged neuron configuration: 8x2-bit weights, threshold, decay and refractory period.
- Commits the configuration atomically, so the neuron never sees a half-written parameter set.
- Drives the neuron's enable once a good frame has been committed and run is requested.

Parameters:
- RST_WEIGHTS, 16'h0000, weights value after reset.
- RST_THRESHOLD, 5'd15, threshold value after reset.
- RST_DECAY, 3'd1, decay value after reset.
- RST_REFRACTORY, 5'd4, refractory_period value after reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  cfg_data/cfg_sof valid this cycle.
- cfg_ready  out  1  loader can accept a byte; a byte transfers when cfg_valid & cfg_ready.
- cfg_sof  in  1  marks the first byte of a frame.
- cfg_data  in  8  config byte.
- run  in  1  user request to run the neuron.
- weights  out  16  active weights; weight i = bits [2i+1:2i].
- threshold  out  5  active threshold.
- decay  out  3  active decay.
- refractory_period  out  5  active refractory period.
- cfg_loaded  out  1  sticky; high once at least one frame has been committed.
- neuron_enable  out  1  run & cfg_loaded, registered.
- frame_error  out  1  one-cycle pulse on any rejected or aborted frame.

Behaviour:
- Frame layout, 4 bytes:
  - B0 = weights[7:0].
  - B1 = weights[15:8].
  - B2 = {decay[2:0], threshold[4:0]}.
  - B3 = {3'b000, refractory[4:0]}.
- Staging: a 4-byte staging register and a 2-bit byte index.
- Active outputs are separate registers, changed only at COMMIT.
- States:
  - IDLE: cfg_ready=1.
    - Accepted byte with cfg_sof=1 -> store as B0, index=1, go to COLLECT.
    - Accepted byte with cfg_sof=0 -> discard, pulse frame_error, stay in IDLE.
  - COLLECT: cfg_ready=1.
    - Accepted byte with cfg_sof=0 -> store at index, index+1.
    - When the byte at index 3 is accepted -> go to CHECK.
    - Accepted byte with cfg_sof=1 -> abort the partial frame, pulse frame_error, store this byte as the new B0, index=1, stay in COLLECT.
  - CHECK: cfg_ready=0. B3[7:5] must be 0.
    - Pass -> COMMIT.
    - Fail -> pulse frame_error, go to IDLE; active outputs unchanged.
  - COMMIT: cfg_ready=0.
    - Copy staging to the active outputs and set cfg_loaded=1.
    - Go to IDLE.
- Latency: the active outputs change 2 cycles after the edge that accepts B3. Max throughput is 1 frame per 6 cycles.
- The staging register is never visible on the outputs; the active outputs are stable throughout collection.
- neuron_enable is registered: it rises 1 cycle after run & cfg_loaded becomes true and falls 1 cycle after run deasserts.
- A new commit while neuron_enable is high is allowed; the new parameters take effect from the commit cycle.
- Reset, including mid-frame:
  - State=IDLE, index=0, staging cleared.
  - Active outputs take the RST_* values.
  - cfg_loaded=0, neuron_enable=0, frame_error=0.
  - cfg_ready=0 during the reset cycle, and 1 on the first cycle after.
- cfg_data is ignored whenever cfg_valid=0 or cfg_ready=0; there is no buffering.

Optional Feature:
- Macro: LIF_CFG_CHECKSUM_EN.
- When defined:
  - The frame is 5 bytes; B4 = B0^B1^B2^B3.
  - COLLECT ends after B4.
  - CHECK additionally requires the XOR to match; a mismatch pulses frame_error and the frame is not committed.
  - Latency is still 2 cycles after the edge that accepts the last byte.
- When undefined: a 4-byte frame, and there is no checksum logic.

Decomposition:
- Package lif_cfg_pkg holds:
  - State enum: IDLE, COLLECT, CHECK, COMMIT.
  - FRAME_BYTES, which is 4, or 5 under the macro.
  - Field widths: WEIGHT_W=16, THRESH_W=5, DECAY_W=3, REFR_W=5.
  - Byte index constants.
- One sub-module: lif_cfg_frame_check. It is combinational, checking the reserved bits and (optionally) the checksum, and produces frame_ok.

Test Plan:
- Reset then idle: weights=0000, threshold=15, decay=1, refractory_period=4, cfg_loaded=0, neuron_enable=0.
- Frame 34,12,A6,07 with sof on the first byte, then run=1 -> weights=1234, threshold=6, decay=5, refractory_period=7 exactly 2 cycles after B3 is accepted; cfg_loaded=1; neuron_enable high 1 cycle after.
- Frame 34,12 then a new sof frame FF,FF,1F,00 -> one frame_error pulse; final weights=FFFF, threshold=31, decay=0, refractory_period=0; no intermediate commit.
- Frame with B3=E7 -> frame_error pulses; outputs keep their previous values; cfg_loaded is unchanged.
- Stray byte without sof in IDLE -> frame_error pulses and the byte is discarded; the next good frame commits normally.
- Reset asserted after B2 of a frame -> RST_* values restored; the remaining B3 (sof=0) is rejected with frame_error. With LIF_CFG_CHECKSUM_EN: frame 34,12,A6,07 plus checksum 87 commits, and plus 00 is rejected.
